// File: rtl/uart_tx_ctrl.sv
// UART transmitter with a one-entry holding register; bits advance only on bit_tick, tx_out is registered.
// Latency: a held frame starts on the next bit_tick from IDLE. Backpressure: ready low while holding is full.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bit_tick,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic                  two_stop,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  ready
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP1  = 3'd4;
   localparam logic [2:0] S_STOP2  = 3'd5;

   logic [2:0]            r_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_par_en;
   logic                  r_parity;
   logic                  r_two_stop;
   logic                  r_tx;
   logic                  r_busy;

   logic                  r_ready;
   logic [DATA_WIDTH-1:0] r_hold_data;
   logic                  r_hold_par_en;
   logic                  r_hold_par_typ;
   logic                  r_hold_two_stop;

   logic w_capture;
   logic w_final;
   logic w_load;

   assign w_capture = Data_Valid && r_ready;
   assign w_final   = ((r_state == S_STOP1) && !r_two_stop) || (r_state == S_STOP2);
   // Holding contents move into the frame registers from IDLE or straight out of the last stop bit.
   assign w_load    = bit_tick && !r_ready && ((r_state == S_IDLE) || w_final);

   assign tx_out = r_tx;
   assign busy   = r_busy;
   assign ready  = r_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_shift         <= '0;
         r_cnt           <= '0;
         r_par_en        <= 1'b0;
         r_parity        <= 1'b0;
         r_two_stop      <= 1'b0;
         r_tx            <= 1'b1;
         r_busy          <= 1'b0;
         r_ready         <= 1'b1;
         r_hold_data     <= '0;
         r_hold_par_en   <= 1'b0;
         r_hold_par_typ  <= 1'b0;
         r_hold_two_stop <= 1'b0;
      end else begin
         if (w_capture) begin
            r_hold_data     <= P_DATA;
            r_hold_par_en   <= par_en;
            r_hold_par_typ  <= par_typ;
            r_hold_two_stop <= two_stop;
         end

         // A capture in the emptying cycle wins, so the new data stays held.
         if (w_capture) begin
            r_ready <= 1'b0;
         end else if (w_load) begin
            r_ready <= 1'b1;
         end

         if (w_load) begin
            r_state    <= S_START;
            r_shift    <= r_hold_data;
            r_cnt      <= '0;
            r_par_en   <= r_hold_par_en;
            r_parity   <= (^r_hold_data) ^ r_hold_par_typ;
            r_two_stop <= r_hold_two_stop;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
         end else if (bit_tick) begin
            case (r_state)
               S_IDLE: begin
                  r_tx   <= 1'b1;
                  r_busy <= 1'b0;
               end
               S_START: begin
                  r_state <= S_DATA;
                  r_cnt   <= '0;
                  r_tx    <= r_shift[0];
               end
               S_DATA: begin
                  if (r_cnt == LAST_BIT) begin
                     r_state <= r_par_en ? S_PARITY : S_STOP1;
                     r_tx    <= r_par_en ? r_parity : 1'b1;
                  end else begin
                     r_shift <= r_shift >> 1;
                     r_cnt   <= r_cnt + CNT_W'(1);
                     r_tx    <= r_shift[1];
                  end
               end
               S_PARITY: begin
                  r_state <= S_STOP1;
                  r_tx    <= 1'b1;
               end
               S_STOP1: begin
                  r_tx <= 1'b1;
                  if (r_two_stop) begin
                     r_state <= S_STOP2;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               S_STOP2: begin
                  r_state <= S_IDLE;
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: expected line bits are queued at offer time and popped by a monitor on each bit_tick.
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       bit_tick = 1'b0;
   logic [7:0] P_DATA = 8'h00;
   logic       Data_Valid = 1'b0;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       two_stop = 1'b0;
   logic       tx_out;
   logic       busy;
   logic       ready;

   int checks = 0;
   int errors = 0;
   bit exp_q[$];
   bit tick_en = 1'b1;
   bit mon_en = 1'b0;
   int tcnt = 0;

   uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .bit_tick   (bit_tick),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .two_stop   (two_stop),
      .tx_out     (tx_out),
      .busy       (busy),
      .ready      (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Baud strobe: one pulse every 4th cycle while enabled.
   initial begin
      forever begin
         @(negedge clk);
         if (tick_en) begin
            tcnt = (tcnt + 1) % 4;
            bit_tick = (tcnt == 0);
         end else begin
            bit_tick = 1'b0;
         end
      end
   end

   // Monitor: pops one expected bit per busy bit_tick and checks the line holds between ticks.
   initial begin : monitor
      logic t, r, last_tx, last_busy;
      bit   e;
      last_tx = 1'b1;
      last_busy = 1'b0;
      forever begin
         @(posedge clk);
         t = bit_tick;
         r = reset;
         #1;
         if (!r) begin
            check("rst_tx", tx_out, 1);
            check("rst_busy", busy, 0);
            check("rst_ready", ready, 1);
            last_tx = 1'b1;
            last_busy = 1'b0;
            mon_en = 1'b1;
         end else if (mon_en) begin
            if (t) begin
               if (busy === 1'b1) begin
                  if (exp_q.size() == 0) begin
                     check("tx_unexpected_busy", busy, 0);
                  end else begin
                     e = exp_q.pop_front();
                     check("tx_bit", tx_out, e);
                  end
               end else begin
                  check("tx_idle", tx_out, 1);
               end
               last_tx = tx_out;
               last_busy = busy;
            end else begin
               check("tx_hold", tx_out, last_tx);
               check("busy_hold", busy, last_busy);
            end
         end
      end
   end

   task automatic push_frame(input logic [7:0] d, input bit pe, input bit pt, input bit ts, input int keep);
      bit b[$];
      b.push_back(1'b0);
      for (int i = 0; i < 8; i++) b.push_back(d[i]);
      if (pe) b.push_back((^d) ^ pt);
      b.push_back(1'b1);
      if (ts) b.push_back(1'b1);
      for (int i = 0; i < b.size() && i < keep; i++) exp_q.push_back(b[i]);
   endtask

   // Offer one frame; inputs are scrambled afterwards so mid-frame changes are exercised.
   task automatic offer(input logic [7:0] d, input bit pe, input bit pt, input bit ts, input int keep);
      for (int i = 0; i < 500 && ready !== 1'b1; i++) @(negedge clk);
      if (ready !== 1'b1) check("offer_ready_timeout", ready, 1);
      push_frame(d, pe, pt, ts, keep);
      P_DATA = d;
      par_en = pe;
      par_typ = pt;
      two_stop = ts;
      Data_Valid = 1'b1;
      @(negedge clk);
      Data_Valid = 1'b0;
      P_DATA = ~d;
      par_en = ~pe;
      par_typ = ~pt;
      two_stop = ~ts;
   endtask

   task automatic wait_q(input int n);
      int i;
      for (i = 0; i < 2000 && exp_q.size() > n; i++) @(negedge clk);
      if (exp_q.size() > n) check("wait_q_timeout", exp_q.size(), n);
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 2000 && !(exp_q.size() == 0 && busy === 1'b0 && ready === 1'b1); i++)
         @(negedge clk);
      check("idle_queue", exp_q.size(), 0);
      check("idle_busy", busy, 0);
      check("idle_ready", ready, 1);
      check("idle_tx", tx_out, 1);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int gaps;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_tx", tx_out, 1);
      check("post_rst_busy", busy, 0);
      check("post_rst_ready", ready, 1);
      repeat (8) @(negedge clk);

      // 0xA5, no parity, one stop: line 0,1,0,1,0,0,1,0,1,1
      offer(8'hA5, 0, 0, 0, 99);
      wait_q(9);
      check("a5_busy_start", busy, 1);
      wait_idle();

      // 0x81 even then odd parity
      offer(8'h81, 1, 0, 0, 99);
      wait_idle();
      offer(8'h81, 1, 1, 0, 99);
      wait_idle();

      // 0x00 with two stop bits
      offer(8'h00, 0, 0, 1, 99);
      wait_idle();

      // Back-to-back: 0x0F held behind 0x55, 0x33 refused while full
      offer(8'h55, 0, 0, 0, 99);
      wait_q(7);
      offer(8'h0F, 0, 0, 0, 99);
      check("b2b_ready_low", ready, 0);
      P_DATA = 8'h33;
      Data_Valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("b2b_ready_held_low", ready, 0);
      end
      Data_Valid = 1'b0;
      gaps = 0;
      for (int i = 0; i < 2000 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) gaps++;
      end
      check("b2b_gap_cycles", gaps, 0);
      wait_idle();
      repeat (16) @(negedge clk);

      // Reset during DATA bit 3 of 0xC3 with 0x77 held: both discarded
      offer(8'hC3, 0, 0, 0, 5);
      wait_q(4);
      offer(8'h77, 0, 0, 0, 0);
      check("rst_hold_full", ready, 0);
      wait_q(0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("midrst_tx", tx_out, 1);
      check("midrst_busy", busy, 0);
      check("midrst_ready", ready, 1);
      repeat (80) @(negedge clk);
      check("midrst_quiet_busy", busy, 0);
      check("midrst_quiet_tx", tx_out, 1);

      // Stall bit_tick for 50 cycles mid-DATA of 0x3C, odd parity, two stops
      offer(8'h3C, 1, 1, 1, 99);
      wait_q(9);
      tick_en = 1'b0;
      repeat (50) @(negedge clk);
      check("stall_busy", busy, 1);
      check("stall_queue", exp_q.size(), 9);
      tick_en = 1'b1;
      wait_idle();
      repeat (12) @(negedge clk);

      check("final_queue", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port bit_tick  input  1  one-cycle baud strobe; every bit period is bounded by bit_tick pulses.
REQ-005 SHALL have port P_DATA  input  DATA_WIDTH  parallel frame data.
REQ-006 SHALL have port Data_Valid  input  1  sender offers P_DATA and config.
REQ-007 SHALL have port par_en  input  1  1 = parity bit present.
REQ-008 SHALL have port par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port two_stop  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 SHALL have port tx_out  output  1  registered serial line, idle high.
REQ-011 SHALL have port busy  output  1  registered; 1 while FSM state is not IDLE.
REQ-012 SHALL have port ready  output  1  1 when the one-entry holding register is empty.

Function
REQ-013 SHALL complete a transfer only in a cycle with Data_Valid=1 and ready=1, capturing P_DATA, par_en, par_typ and two_stop into the holding register and setting it full.
REQ-014 SHALL ignore Data_Valid while ready=0, with no capture and no state change.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP1, STOP2, and SHALL change state only in cycles with bit_tick=1.
REQ-016 In IDLE with holding full and bit_tick=1, SHALL go to START, move the holding contents into the shift/config registers, and clear the holding register.
REQ-017 A capture in the same cycle as IDLE bit_tick with holding empty SHALL NOT start a frame; the frame starts at the next bit_tick.
REQ-018 A capture in the same cycle the holding register is emptied (REQ-016/022) SHALL leave the holding register full with the new data.
REQ-019 On bit_tick: START->DATA with bit counter 0; DATA shifts right and increments the counter.
REQ-020 On bit_tick in DATA with counter = DATA_WIDTH-1: go to PARITY if par_en else STOP1.
REQ-021 On bit_tick: PARITY->STOP1; STOP1->STOP2 if two_stop.
REQ-022 On bit_tick in the final stop state: go to START (loading the holding register as in REQ-016) if holding is full, else go to IDLE.
REQ-023 tx_out SHALL be updated on each bit_tick transition to the bit of the entered state: START=0; DATA=shift[0], LSB first; PARITY=XOR of frame data XOR par_typ; STOP1/STOP2/IDLE=1.
REQ-024 Each bit SHALL therefore be held on tx_out from the cycle after one bit_tick through the cycle of the next bit_tick.
REQ-025 Config used by a frame SHALL be the values captured with its data; input changes mid-frame SHALL have no effect.
REQ-026 Back-to-back frames SHALL have zero idle bits between the last stop bit and the next start bit.
REQ-027 With bit_tick=0 all state, counters and outputs SHALL hold, except the holding-register capture.
REQ-028 ready SHALL be a registered state bit, not combinational from Data_Valid.

Reset
REQ-029 In a cycle with reset=0, SHALL set state=IDLE, tx_out=1, busy=0, holding empty (ready=1), counter=0, shift=0 at the clock edge.
REQ-030 A reset mid-frame SHALL abort the frame and discard held data, with no partial bits after the edge.
REQ-031 Reset SHALL take priority over bit_tick and Data_Valid in the same cycle.

Verification (DATA_WIDTH=8, bit_tick every 4th cycle)
REQ-032 Send 0xA5 with par_en=0, two_stop=0 -> tx_out is 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; busy=1 from START through STOP1, then 0.
REQ-033 Send 0x81 with par_en=1, par_typ=0 -> parity bit 0; repeat with par_typ=1 -> parity bit 1; frame is 11 bits.
REQ-034 Send 0x00 with two_stop=1 -> two 1-bit stop periods (8 cycles high) before IDLE.
REQ-035 Send 0x55, then offer 0x0F during its DATA -> ready drops to 0 after capture; a third Data_Valid (0x33) is ignored; the 0x0F START bit immediately follows the 0x55 stop bit; 0x33 is never transmitted.
REQ-036 Assert reset=0 for one cycle during DATA bit 3 -> next cycle tx_out=1, busy=0, ready=1; no further frame output.
REQ-037 Hold bit_tick=0 for 50 cycles mid-DATA -> tx_out and busy remain constant; transmission resumes on the next bit_tick.
